wave_capture: RTL
=================

Name: wave_capture

Overview:
- Acquisition stage directly upstream of the SSD1306 waveform plotter peripheral.
- Samples an 8-channel logic bus at a programmable rate and waits for a trigger condition.
- After triggering, captures a programmed number of samples into a small FIFO.
- The CPU, or a DMA-like feeder, pops samples from the FIFO and forwards each byte to the plotter's pixel command.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- LVL_W, $clog2(DEPTH)+1, width of level output.

Ports:
- clk  in  1  system clock (64 MHz nominal)
- rst_n  in  1  asynchronous reset, active low
- sample_in  in  8  already-synchronised logic channels
- cfg_wr  in  1  register write strobe, single cycle
- cfg_addr  in  3  register select
- cfg_data  in  8  register write data
- pop  in  1  consume head sample; ignored when empty
- rd_data  out  8  FIFO head; valid when empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  LVL_W  occupied entries, 0..DEPTH
- status  out  8  {state[1:0], overflow, full, empty, 3'b0}
- irq  out  1  one-cycle pulse on CAPTURE->DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO pointers=0; rd_data=0; empty=1; full=0; level=0; overflow=0; irq=0.
  - div=0; trig cfg=0; count=0.
- Registers:
  - 0: div[7:0]; sample period is div+1 clocks.
  - 1: trig {mode[6:5], chan[2:0]}.
    - mode 00 = immediate, 01 = rising, 10 = falling, 11 = either edge.
  - 2: count; number of samples; 0 means 256.
  - 3: ctrl, write-only. bit0 = arm, bit1 = abort. Reads as 0.
  - Writes to 0–2 are ignored unless state is IDLE or DONE.
- Sample tick:
  - Divider counter loads div on arm and reloads div on each tick.
  - Otherwise it decrements.
  - tick = (counter==0) while in ARMED or CAPTURE. No ticks in IDLE/DONE.
- States:
  - IDLE:
    - arm -> ARMED. Arm flushes the FIFO, clears overflow, loads prev=sample_in, and loads remaining=count.
  - ARMED:
    - On tick, evaluate the trigger using sample_in[chan] vs prev[chan]; prev<=sample_in each tick.
    - Immediate mode triggers on the first tick.
    - On trigger, the triggering sample is pushed as sample 1 and state -> CAPTURE, or -> DONE if remaining==1.
  - CAPTURE:
    - Each tick pushes sample_in and decrements remaining.
    - The push that brings remaining to 0 moves state -> DONE and pulses irq in the following cycle.
  - DONE:
    - FIFO drains by pop.
    - arm re-arms exactly as from IDLE.
  - Abort in any state -> IDLE in the next cycle. FIFO contents are kept; abort has priority over arm and over a trigger in the same cycle.
  - Arm while ARMED or CAPTURE is ignored.
- FIFO:
  - Registered storage; rd_data = mem[rd_ptr], combinational from the registers.
  - Push while full with no pop in the same cycle: sample dropped, overflow sticky set, remaining still decrements (capture stays time-accurate).
  - Simultaneous push and pop when full: both take effect, level unchanged, no overflow.
  - Simultaneous push and pop when empty: the push is accepted, the pop is ignored, and level becomes 1.
  - Pointers wrap modulo DEPTH with an extra wrap bit; full = (level==DEPTH).
- Latency:
  - A pushed sample appears on rd_data/empty one cycle after the tick.
  - pop updates rd_data the next cycle.

Optional Feature:
- Macro WAVE_CAPTURE_PATTERN_EN. When defined:
  - Register 4 holds mask[7:0] and register 5 holds value[7:0]. Both reset to 0.
  - mode 11 means pattern trigger: the trigger fires on the first tick where (sample_in & mask) == (value & mask); chan is ignored.
- When undefined:
  - Registers 4/5 do not exist; writes are ignored.
  - mode 11 is either-edge.

Test Plan:
- Immediate capture:
  - Stimulus: div=0, count=4, mode 00; arm; sample_in steps A1,B2,C3,D4 each clock.
  - Required: FIFO holds A1,B2,C3,D4; irq pulses once; status state=DONE; level=4.
- Rising trigger:
  - Stimulus: div=3, chan=2, mode 01, count=2; bit2 rises at cycle 20.
  - Required: first stored sample is from the first tick seeing bit2=1; second sample is taken 4 clocks later.
- Overflow:
  - Stimulus: DEPTH=8, count=10, no pops.
  - Required: level=8, overflow=1, the first 8 samples are retained, DONE is reached after 10 ticks.
- Full plus simultaneous push/pop:
  - Stimulus: FIFO full; assert pop exactly on a tick.
  - Required: level stays 8, overflow stays 0, head advances.
- Abort and async reset:
  - Stimulus: abort during CAPTURE.
  - Required: next cycle state=IDLE, FIFO retained, no irq.
  - Stimulus: rst_n low mid-capture.
  - Required: immediately empty=1, level=0, status=8'h08.
- Pattern trigger (WAVE_CAPTURE_PATTERN_EN):
  - Stimulus: mask=F0, value=A0; input 0x5F, then 0xA7.
  - Required: trigger fires on the 0xA7 tick; 0xA7 is stored first.

Source files
------------

// File: rtl/wave_capture_if.sv
// wave_capture_if -- sample, config and FIFO read-side bus of wave_capture. rev 1.0
`default_nettype none

interface wave_capture_if #(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
);
  logic [7:0]       sample_in;
  logic             cfg_wr;
  logic [2:0]       cfg_addr;
  logic [7:0]       cfg_data;
  logic             pop;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic [7:0]       status;
  logic             irq;

  modport master (
    output sample_in, cfg_wr, cfg_addr, cfg_data, pop,
    input  rd_data, empty, full, level, status, irq
  );

  modport slave (
    input  sample_in, cfg_wr, cfg_addr, cfg_data, pop,
    output rd_data, empty, full, level, status, irq
  );
endinterface

`default_nettype wire

// File: rtl/wave_capture.sv
// wave_capture -- triggered logic-bus sampler feeding a small FIFO; optional pattern
// trigger under WAVE_CAPTURE_PATTERN_EN. rev 1.0
`default_nettype none

module wave_capture #(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  wave_capture_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       div;
  logic [1:0]       trig_mode;
  logic [2:0]       trig_chan;
  logic [7:0]       count;
  logic [7:0]       div_cnt;
  logic [7:0]       prev;
  logic [8:0]       remaining;
  logic             irq;
`ifdef WAVE_CAPTURE_PATTERN_EN
  logic [7:0]       pat_mask;
  logic [7:0]       pat_value;
`endif

  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;

  logic cfg_ok;
  logic ctrl_wr;
  logic abort;
  logic arm_go;
  logic tick;
  logic hit;
  logic push;
  logic push_ok;
  logic pop_ok;
  logic fifo_empty;
  logic fifo_full;

  assign cfg_ok     = (state == IDLE) || (state == DONE);
  assign ctrl_wr    = bus.cfg_wr && (bus.cfg_addr == 3'd3);
  assign abort      = ctrl_wr && bus.cfg_data[1];
  assign arm_go     = ctrl_wr && bus.cfg_data[0] && !abort && cfg_ok;
  assign tick       = ((state == ARMED) || (state == CAPTURE)) && (div_cnt == 8'd0);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));

  always_comb begin
    logic cur;
    logic old;
    cur = bus.sample_in[trig_chan];
    old = prev[trig_chan];
    hit = 1'b0;
    unique case (trig_mode)
      2'b00: hit = 1'b1;
      2'b01: hit = cur & ~old;
      2'b10: hit = ~cur & old;
`ifdef WAVE_CAPTURE_PATTERN_EN
      2'b11: hit = ((bus.sample_in & pat_mask) == (pat_value & pat_mask));
`else
      2'b11: hit = cur ^ old;
`endif
      default: hit = 1'b0;
    endcase
  end

  // An abort in the same cycle as a tick wins: nothing is stored.
  assign push    = tick && !abort && ((state == CAPTURE) || ((state == ARMED) && hit));
  assign pop_ok  = bus.pop && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= 8'd0;
      trig_mode <= 2'b00;
      trig_chan <= 3'd0;
      count     <= 8'd0;
      div_cnt   <= 8'd0;
      prev      <= 8'd0;
      remaining <= 9'd0;
      irq       <= 1'b0;
`ifdef WAVE_CAPTURE_PATTERN_EN
      pat_mask  <= 8'd0;
      pat_value <= 8'd0;
`endif
    end else begin
      irq <= 1'b0;

      if (bus.cfg_wr && cfg_ok) begin
        case (bus.cfg_addr)
          3'd0: div <= bus.cfg_data;
          3'd1: begin
            trig_mode <= bus.cfg_data[6:5];
            trig_chan <= bus.cfg_data[2:0];
          end
          3'd2: count <= bus.cfg_data;
`ifdef WAVE_CAPTURE_PATTERN_EN
          3'd4: pat_mask  <= bus.cfg_data;
          3'd5: pat_value <= bus.cfg_data;
`endif
          default: ;
        endcase
      end

      if (arm_go || tick) begin
        div_cnt <= div;
      end else if (div_cnt != 8'd0) begin
        div_cnt <= div_cnt - 8'd1;
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm_go) begin
              state     <= ARMED;
              prev      <= bus.sample_in;
              remaining <= (count == 8'd0) ? 9'd256 : {1'b0, count};
            end
          end
          ARMED: begin
            if (tick) begin
              prev <= bus.sample_in;
              if (hit) begin
                remaining <= remaining - 9'd1;
                if (remaining == 9'd1) begin
                  state <= DONE;
                  irq   <= 1'b1;
                end else begin
                  state <= CAPTURE;
                end
              end
            end
          end
          CAPTURE: begin
            // Dropped samples still consume a slot so the capture window stays time-accurate.
            if (tick) begin
              remaining <= remaining - 9'd1;
              if (remaining == 9'd1) begin
                state <= DONE;
                irq   <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (arm_go) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= bus.sample_in;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  assign bus.rd_data = mem[rd_ptr[AW-1:0]];
  assign bus.empty   = fifo_empty;
  assign bus.full    = fifo_full;
  assign bus.level   = level;
  assign bus.status  = {state, overflow, fifo_full, fifo_empty, 3'b000};
  assign bus.irq     = irq;

endmodule

`default_nettype wire
